// File: rtl/conv_sched_pkg.sv
// Shared types, constants and the round-robin pick helper for the
// convolution-engine scheduler.
package conv_sched_pkg;

  // Scheduler phases: arbitrate, fire the engine, wait for its result, report.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } sched_state_t;

  // Cycles from eng_valid_in to eng_valid_out in the shared Conv2D datapath.
  localparam int ENGINE_LATENCY = 2;

  // Upper bounds for the generic pick helper; callers zero-extend into these.
  localparam int MAX_REQ   = 16;
  localparam int MAX_SEL_W = 4;

  typedef struct packed {
    logic                 valid;
    logic [MAX_SEL_W-1:0] id;
  } pick_t;

  // First set request at or after ptr, scanning upward and wrapping at num_req.
  // ptr must be below num_req.
  function automatic pick_t rr_pick(input logic [MAX_REQ-1:0]   req,
                                    input logic [MAX_SEL_W-1:0] ptr,
                                    input int                   num_req);
    pick_t r;
    int    idx;
    r   = '0;
    idx = 0;
    for (int k = 0; k < MAX_REQ; k++) begin
      if (k < num_req && !r.valid) begin
        idx = int'(ptr) + k;
        if (idx >= num_req) idx = idx - num_req;
        if (req[idx]) begin
          r.valid = 1'b1;
          r.id    = idx[MAX_SEL_W-1:0];
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/conv_engine_scheduler_rr_arbiter.sv
// Round-robin arbiter: combinational pick from the current pointer, and a
// pointer register that moves just past the served requester when a job ends.
module rr_arbiter
  import conv_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int SEL_W   = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               adv,
  input  logic [SEL_W-1:0]   adv_id,
  output logic [SEL_W-1:0]   win_id,
  output logic               win_valid
);

  logic [SEL_W-1:0] ptr_q;
  pick_t            pick;

  // Winner for this cycle, starting the scan at the pointer.
  always_comb begin
    pick = rr_pick(MAX_REQ'(req), MAX_SEL_W'(ptr_q), NUM_REQ);
  end

  assign win_valid = pick.valid;
  assign win_id    = SEL_W'(pick.id);

  // Pointer moves to (served id + 1) mod NUM_REQ so the served requester goes last.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else if (adv) begin
      ptr_q <= (adv_id == SEL_W'(NUM_REQ - 1)) ? '0 : adv_id + SEL_W'(1);
    end
  end

endmodule

// File: rtl/conv_engine_scheduler.sv
// Shares one 2-stage Conv2D engine among NUM_REQ layer requesters.
//
// Handshake: a requester raises req (level) and holds it until it sees its
// one-cycle done pulse. gnt is one-hot and held from ISSUE through DONE;
// eng_sel follows the granted id and keeps its value afterwards. Each job
// issues exactly one eng_valid_in pulse and completes on eng_valid_out or on
// timeout; dropping req mid-job does not cancel it.
module conv_engine_scheduler
  import conv_sched_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int TIMEOUT   = 15,
  parameter int CNT_WIDTH = 16,
  parameter int SEL_W     = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req,
  output logic [NUM_REQ-1:0]   gnt,
  output logic [NUM_REQ-1:0]   done,
  output logic [SEL_W-1:0]     eng_sel,
  output logic                 eng_valid_in,
  input  logic                 eng_valid_out,
  output logic                 busy,
  output logic                 err_timeout,
  output logic                 err_spurious,
  output logic [SEL_W-1:0]     err_id,
  input  logic                 err_clr,
  output logic [CNT_WIDTH-1:0] job_count
);

  localparam int                 WCW = $clog2(TIMEOUT + 1);
  localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

  sched_state_t     state_q, state_d;
  logic [SEL_W-1:0] id_q, id_d;
  logic [WCW-1:0]   wait_q, wait_d;
  logic [SEL_W-1:0] win_id;
  logic             win_valid;
  logic             timeout_hit;
  logic             spurious_hit;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .SEL_W   (SEL_W)
  ) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .adv       (state_q == DONE),
    .adv_id    (id_q),
    .win_id    (win_id),
    .win_valid (win_valid)
  );

  // Next-state logic: arbitrate, fire, wait with timeout, report.
  always_comb begin
    state_d      = state_q;
    id_d         = id_q;
    wait_d       = wait_q;
    timeout_hit  = 1'b0;
    case (state_q)
      IDLE: begin
        if (win_valid) begin
          id_d    = win_id;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        wait_d  = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (eng_valid_out) begin
          state_d = DONE;
        end else if (wait_q == WCW'(TIMEOUT)) begin
          state_d     = DONE;
          timeout_hit = 1'b1;
        end else begin
          wait_d = wait_q + WCW'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // A result outside WAIT belongs to no job (late, or lost across a reset).
    spurious_hit = eng_valid_out && (state_q != WAIT);
  end

  // State, registered outputs derived from the next state, counters and flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      id_q         <= '0;
      wait_q       <= '0;
      gnt          <= '0;
      done         <= '0;
      eng_sel      <= '0;
      eng_valid_in <= 1'b0;
      busy         <= 1'b0;
      err_timeout  <= 1'b0;
      err_spurious <= 1'b0;
      err_id       <= '0;
      job_count    <= '0;
    end else begin
      state_q      <= state_d;
      id_q         <= id_d;
      wait_q       <= wait_d;
      busy         <= (state_d != IDLE);
      eng_valid_in <= (state_d == ISSUE);
      gnt          <= (state_d != IDLE) ? (ONE << id_d) : '0;
      done         <= (state_d == DONE) ? (ONE << id_d) : '0;
      if (state_d == ISSUE) eng_sel <= id_d;
      if (state_d == DONE) job_count <= job_count + CNT_WIDTH'(1);
      // A new error event in the same cycle as err_clr keeps the flag set.
      if (timeout_hit) begin
        err_timeout <= 1'b1;
        err_id      <= id_q;
      end else if (err_clr) begin
        err_timeout <= 1'b0;
        err_id      <= '0;
      end
      if (spurious_hit)  err_spurious <= 1'b1;
      else if (err_clr)  err_spurious <= 1'b0;
    end
  end

endmodule

// File: tb/tb_conv_engine_scheduler.sv
// Directed bench for conv_engine_scheduler with a 2-cycle stub engine.
module tb_conv_engine_scheduler;
  import conv_sched_pkg::*;

  localparam int NR = 4;
  localparam int TO = 15;
  localparam int CW = 4;
  localparam int SW = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NR-1:0] req;
  logic [NR-1:0] gnt;
  logic [NR-1:0] done;
  logic [SW-1:0] eng_sel;
  logic          eng_valid_in;
  logic          eng_valid_out;
  logic          busy;
  logic          err_timeout;
  logic          err_spurious;
  logic [SW-1:0] err_id;
  logic          err_clr;
  logic [CW-1:0] job_count;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic                      stub_en;
  logic [ENGINE_LATENCY-1:0] sr;

  conv_engine_scheduler #(
    .NUM_REQ   (NR),
    .TIMEOUT   (TO),
    .CNT_WIDTH (CW),
    .SEL_W     (SW)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req           (req),
    .gnt           (gnt),
    .done          (done),
    .eng_sel       (eng_sel),
    .eng_valid_in  (eng_valid_in),
    .eng_valid_out (eng_valid_out),
    .busy          (busy),
    .err_timeout   (err_timeout),
    .err_spurious  (err_spurious),
    .err_id        (err_id),
    .err_clr       (err_clr),
    .job_count     (job_count)
  );

  always #5 clk = ~clk;

  // One clock; stub engine echoes eng_valid_in ENGINE_LATENCY edges later.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (stub_en) begin
      eng_valid_out = sr[ENGINE_LATENCY-1];
      sr = {sr[ENGINE_LATENCY-2:0], eng_valid_in};
    end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0; req = '0; err_clr = 1'b0; eng_valid_out = 1'b0;
    sr = '0; stub_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    rst_n = 1'b0;
    step(); step();
    n_checks++;
    if ({gnt, done, eng_sel, eng_valid_in, busy, err_timeout, err_spurious, err_id, job_count} !== '0) begin
      n_fail++;
      $display("FAIL reset_hold: gnt=%b done=%b sel=%0d vin=%b busy=%b et=%b es=%b eid=%0d cnt=%0d, want all 0",
               gnt, done, eng_sel, eng_valid_in, busy, err_timeout, err_spurious, err_id, job_count);
    end
    rst_n = 1'b1;
    step();
    n_checks++;
    if ({gnt, done, eng_valid_in, busy, job_count} !== '0) begin
      n_fail++;
      $display("FAIL reset_idle: gnt=%b done=%b vin=%b busy=%b cnt=%0d, want all 0",
               gnt, done, eng_valid_in, busy, job_count);
    end
  endtask

  task automatic test_single();
    apply_reset();
    req = 4'b0100;
    step();
    n_checks++;
    if (gnt !== 4'b0100 || eng_valid_in !== 1'b1 || eng_sel !== 2'd2 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL single_issue: gnt=%b vin=%b sel=%0d busy=%b, want 0100 1 2 1", gnt, eng_valid_in, eng_sel, busy);
    end
    step();
    n_checks++;
    if (gnt !== 4'b0100 || eng_valid_in !== 1'b0 || done !== 4'b0000) begin
      n_fail++;
      $display("FAIL single_wait: gnt=%b vin=%b done=%b, want 0100 0 0000", gnt, eng_valid_in, done);
    end
    step(); step();
    n_checks++;
    if (done !== 4'b0100 || job_count !== 4'd1 || gnt !== 4'b0100) begin
      n_fail++;
      $display("FAIL single_done: done=%b cnt=%0d gnt=%b, want 0100 1 0100", done, job_count, gnt);
    end
    req = '0;
    step();
    n_checks++;
    if (done !== 4'b0000 || gnt !== 4'b0000 || busy !== 1'b0 || eng_sel !== 2'd2 || job_count !== 4'd1) begin
      n_fail++;
      $display("FAIL single_idle: done=%b gnt=%b busy=%b sel=%0d cnt=%0d, want 0000 0000 0 2 1",
               done, gnt, busy, eng_sel, job_count);
    end
  endtask

  task automatic test_fairness();
    int         gcount [NR];
    int         prev;
    bit         found;
    logic [3:0] exp_g;
    apply_reset();
    for (int b = 0; b < NR; b++) gcount[b] = 0;
    prev = 0;
    req = 4'b1111;
    for (int j = 0; j < 20; j++) begin
      found = 1'b0;
      for (int t = 0; t < 8; t++) begin
        step();
        if (eng_valid_in === 1'b1) begin
          found = 1'b1;
          break;
        end
      end
      exp_g = 4'b0001 << (j % 4);
      n_checks++;
      if (!found || gnt !== exp_g) begin
        n_fail++;
        $display("FAIL fair_grant job %0d: found=%b gnt=%b, want 1 %b", j, found, gnt, exp_g);
      end
      for (int b = 0; b < NR; b++) if (gnt[b] === 1'b1) gcount[b]++;
      if (j > 0) begin
        n_checks++;
        if (cyc - prev != 5) begin
          n_fail++;
          $display("FAIL fair_spacing job %0d: got %0d cycles, want 5", j, cyc - prev);
        end
      end
      prev = cyc;
    end
    req = '0;
    repeat (6) step();
    for (int b = 0; b < NR; b++) begin
      n_checks++;
      if (gcount[b] != 5) begin
        n_fail++;
        $display("FAIL fair_count id %0d: got %0d grants, want 5", b, gcount[b]);
      end
    end
    // 20 jobs through a 4-bit counter wraps past 15 back to 4.
    n_checks++;
    if (job_count !== 4'd4 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL fair_wrap: cnt=%0d busy=%b, want 4 0", job_count, busy);
    end
  endtask

  task automatic test_timeout();
    bit found;
    apply_reset();
    stub_en = 1'b0;
    eng_valid_out = 1'b0;
    req = 4'b0010;
    found = 1'b0;
    for (int t = 0; t < 4; t++) begin
      step();
      if (eng_valid_in === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
    n_checks++;
    if (!found || gnt !== 4'b0010) begin
      n_fail++;
      $display("FAIL to_issue: found=%b gnt=%b, want 1 0010", found, gnt);
    end
    repeat (TO + 1) step();
    n_checks++;
    if (done !== 4'b0000 || busy !== 1'b1 || err_timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL to_not_early: done=%b busy=%b et=%b, want 0000 1 0", done, busy, err_timeout);
    end
    step();
    n_checks++;
    if (done !== 4'b0010 || err_timeout !== 1'b1 || err_id !== 2'd1 || job_count !== 4'd1) begin
      n_fail++;
      $display("FAIL to_done: done=%b et=%b eid=%0d cnt=%0d, want 0010 1 1 1", done, err_timeout, err_id, job_count);
    end
    req = '0;
    step();
    n_checks++;
    if (err_timeout !== 1'b1 || err_id !== 2'd1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL to_sticky: et=%b eid=%0d busy=%b, want 1 1 0", err_timeout, err_id, busy);
    end
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    n_checks++;
    if (err_timeout !== 1'b0 || err_id !== 2'd0) begin
      n_fail++;
      $display("FAIL to_clear: et=%b eid=%0d, want 0 0", err_timeout, err_id);
    end
  endtask

  task automatic test_spurious();
    stub_en = 1'b0;
    eng_valid_out = 1'b1;
    step();
    eng_valid_out = 1'b0;
    n_checks++;
    if (err_spurious !== 1'b1 || gnt !== 4'b0000 || done !== 4'b0000 || busy !== 1'b0 || job_count !== 4'd1) begin
      n_fail++;
      $display("FAIL sp_idle: es=%b gnt=%b done=%b busy=%b cnt=%0d, want 1 0000 0000 0 1",
               err_spurious, gnt, done, busy, job_count);
    end
    err_clr = 1'b1;
    eng_valid_out = 1'b1;
    step();
    eng_valid_out = 1'b0;
    n_checks++;
    if (err_spurious !== 1'b1) begin
      n_fail++;
      $display("FAIL sp_set_wins: es=%b, want 1", err_spurious);
    end
    step();
    err_clr = 1'b0;
    n_checks++;
    if (err_spurious !== 1'b0) begin
      n_fail++;
      $display("FAIL sp_clear: es=%b, want 0", err_spurious);
    end
    sr = '0;
    stub_en = 1'b1;
  endtask

  task automatic test_reset_mid_job();
    bit found;
    apply_reset();
    req = 4'b0001;
    found = 1'b0;
    for (int t = 0; t < 4; t++) begin
      step();
      if (eng_valid_in === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
    step();
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (!found || {gnt, done, eng_valid_in, busy} !== '0 || job_count !== 4'd0) begin
      n_fail++;
      $display("FAIL rst_async: found=%b gnt=%b done=%b vin=%b busy=%b cnt=%0d, want 1 0000 0000 0 0 0",
               found, gnt, done, eng_valid_in, busy, job_count);
    end
    sr = '0;
    eng_valid_out = 1'b0;
    step(); step();
    rst_n = 1'b1;
    found = 1'b0;
    for (int t = 0; t < 4; t++) begin
      step();
      if (eng_valid_in === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
    n_checks++;
    if (!found || gnt !== 4'b0001) begin
      n_fail++;
      $display("FAIL rst_regrant: found=%b gnt=%b, want 1 0001", found, gnt);
    end
    for (int t = 0; t < 8; t++) begin
      step();
      if (done !== 4'b0000) break;
    end
    n_checks++;
    if (done !== 4'b0001 || job_count !== 4'd1 || err_timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_rejob: done=%b cnt=%0d et=%b, want 0001 1 0", done, job_count, err_timeout);
    end
    req = '0;
    step();
  endtask

  task automatic test_req_drop();
    bit found;
    apply_reset();
    req = 4'b0100;
    found = 1'b0;
    for (int t = 0; t < 4; t++) begin
      step();
      if (eng_valid_in === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
    n_checks++;
    if (!found || gnt !== 4'b0100) begin
      n_fail++;
      $display("FAIL drop_grant: found=%b gnt=%b, want 1 0100", found, gnt);
    end
    step();
    req = 4'b1001;
    for (int t = 0; t < 8; t++) begin
      step();
      if (done !== 4'b0000) break;
    end
    n_checks++;
    if (done !== 4'b0100) begin
      n_fail++;
      $display("FAIL drop_done: done=%b, want 0100", done);
    end
    found = 1'b0;
    for (int t = 0; t < 4; t++) begin
      step();
      if (eng_valid_in === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
    n_checks++;
    if (!found || gnt !== 4'b1000 || eng_sel !== 2'd3) begin
      n_fail++;
      $display("FAIL drop_next: found=%b gnt=%b sel=%0d, want 1 1000 3", found, gnt, eng_sel);
    end
    req = '0;
    repeat (6) step();
  endtask

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_timeout();
    test_spurious();
    test_reset_mid_job();
    test_req_drop();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
